sfx_scheduler: RTL
==================

# sfx_scheduler

Sound-effect playback scheduler sitting between the Avalon register interface and the audio codec's left/right sample streams. Software triggers up to NUM_SFX effect voices; the block sequences each voice's ROM address, paces samples at a fixed rate from the 50 MHz clock, selects or mixes active voices, and delivers each sample through a per-channel valid/ready handshake. The effect ROMs stay outside the block: it drives their addresses and takes their registered outputs.

## Interface
- NUM_SFX, 4, number of effect voices (IDs 1..NUM_SFX).
- ADDR_W, 10, ROM address width per voice.
- TICK_DIV, 6250, clk cycles per output sample (8 kHz at 50 MHz).
- clk  in  1  system clock; one clock domain.
- reset  in  1  synchronous, active-high.
- writedata  in  32  Avalon write data.
- write  in  1  Avalon write strobe.
- chipselect  in  1  Avalon select.
- address  in  3  register index.
- rom_addr  out  NUM_SFX*ADDR_W  packed ROM addresses, voice v at [v*ADDR_W +: ADDR_W].
- rom_q  in  NUM_SFX*16  packed ROM data, 1-cycle read latency.
- left_chan_ready, right_chan_ready  in  1 each  codec accepts sample.
- sample_data_l, sample_data_r  out  16  signed sample.
- sample_valid_l, sample_valid_r  out  1 each  sample offered.
- active  out  NUM_SFX  voice-playing mask.
- underrun  out  1  sticky; a tick arrived before the previous sample drained.

## Operation
- Register 0 write: writedata[2:0] = ID. ID 1..NUM_SFX starts that voice at address 0, or restarts it if already active. ID 0 stops all voices. IDs above NUM_SFX are ignored.
- Register 1 write: bits [NUM_SFX-1:0] stop the masked voices. Bit 31 clears underrun.
- Other addresses: ignored.
- Voice v plays addresses 0..SFX_LEN[v]-1. After SFX_LEN[v]-1 is consumed, the voice's address wraps to 0 and its active bit clears.
- Inactive voices hold address 0.
- Tick counter runs 0..TICK_DIV-1 continuously from reset. The tick is the cycle in which count == TICK_DIV-1.
- FSM states:
  - IDLE: on tick, go to LATCH.
  - LATCH: capture rom_q of every active voice. Advance each active voice's address, including voices not selected for output. Form the output sample. Go to OUT.
  - OUT: hold both valids high. Each valid drops in the cycle after its ready is seen while that valid is high. When both have dropped, go to IDLE.
- Tick in any state other than IDLE: the tick is dropped, underrun is set, and the FSM is unaffected.
- Output selection without mixing: the lowest-index active voice wins.
- No voice active: the sample is 0, still delivered every tick so the codec stays fed.
- Left and right always carry the same value.
- Retrigger write in the same cycle as LATCH or end-of-voice: the write wins; the voice is active at address 0. The sample captured in that LATCH remains the old one.
- Reset mid-operation, clears on the next edge:
  - all valids, active bits, addresses, the counter and underrun go to 0;
  - the FSM returns to IDLE;
  - sample_data goes to 0.

## Timing
- Reset values: sample_data_l/r = 0, sample_valid_l/r = 0, rom_addr = 0, active = 0, underrun = 0.
- Tick at cycle T:
  - LATCH at T+1;
  - valids high from T+2;
  - sample_data registered and stable throughout OUT.
- ROM addresses are stable at least 1 cycle before LATCH, so rom_q is valid in LATCH.
- With both readys held high, each valid is high for exactly 1 cycle, and the FSM is back in IDLE at T+3.
- A trigger write at cycle W makes active[v] visible at W+1.

## Configuration
- SFX_MIX_EN defined:
  - the output is the sum of all active voices;
  - each voice is sign-extended to 16+clog2(NUM_SFX) bits before summing;
  - the sum saturates to [-32768, 32767].
- SFX_MIX_EN undefined: lowest-index priority selection, no adder.

## Structure
- Package sfx_pkg holds:
  - the SFX_LEN per-voice length constant array (default 1000 each);
  - the FSM state enum (IDLE, LATCH, OUT);
  - the register index constants (REG_TRIGGER = 0, REG_STOP = 1).
- One sub-module, sfx_voice: one instance per voice, holding the address counter, the active bit and start/stop/advance handling.
- The top module holds the tick counter, the FSM, the mix/select logic and the handshake.

## Test plan
- Trigger ID 2, readys tied high, rom_q[voice1] = address value:
  - samples read 0, 1, 2, … at one per 6250 cycles;
  - valid pulses 1 cycle at T+2;
  - active[1] clears after sample 999.
- Trigger IDs 3 then 1, mix off, ROM data 0x1000 and 0x0100 respectively:
  - output is 0x0100 (voice 0 wins);
  - voice 2's address keeps advancing;
  - after voice 0 ends, output returns to voice 2's data.
- Mix on, three voices each outputting 0x7000 → output 0x7FFF. Three voices each 0x9000 → 0x8000.
- Hold left_chan_ready low for 2 ticks:
  - sample_valid_l stays high;
  - sample_valid_r drops after its accept;
  - underrun = 1;
  - a write of 0x8000_0000 to register 1 clears it.
- Retrigger an active voice in the same cycle as its LATCH → address is 0 next cycle and the voice stays active.
- Assert reset while the FSM is in OUT → all outputs are 0 next cycle, and the first post-reset valid comes at cycle TICK_DIV+1 after release.

Source files
------------

// File: rtl/sfx_pkg.sv
// rtl/sfx_pkg.sv - shared constants, FSM states and helpers for the sound-effect scheduler
package sfx_pkg;

  localparam int MAX_SFX = 8;

  // Playback length in samples for each voice slot
  localparam int SFX_LEN [MAX_SFX] = '{1000, 1000, 1000, 1000, 1000, 1000, 1000, 1000};

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LATCH = 2'd1,
    OUT   = 2'd2
  } sfx_state_t;

  localparam logic [2:0] REG_TRIGGER = 3'd0;
  localparam logic [2:0] REG_STOP    = 3'd1;

  function automatic logic [15:0] sat16(input int x);
    if (x > 32767) return 16'h7fff;
    if (x < -32768) return 16'h8000;
    return x[15:0];
  endfunction

endpackage

// File: rtl/sfx_voice.sv
// rtl/sfx_voice.sv - one effect voice: ROM address counter and active flag
module sfx_voice
  import sfx_pkg::*;
#(
  parameter int ADDR_W = 10,
  parameter int LEN    = SFX_LEN[0]
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              stop,
  input  logic              advance,
  output logic [ADDR_W-1:0] addr,
  output logic              active
);

  // A start request outranks both stop and the end-of-voice wrap
  always_ff @(posedge clk) begin
    if (reset) begin
      addr   <= '0;
      active <= 1'b0;
    end else if (start) begin
      addr   <= '0;
      active <= 1'b1;
    end else if (stop) begin
      addr   <= '0;
      active <= 1'b0;
    end else if (advance && active) begin
      if (addr == ADDR_W'(LEN - 1)) begin
        addr   <= '0;
        active <= 1'b0;
      end else begin
        addr <= addr + 1'b1;
      end
    end
  end

endmodule

// File: rtl/sfx_scheduler.sv
// rtl/sfx_scheduler.sv - paces, selects (or mixes with SFX_MIX_EN) and delivers effect samples
module sfx_scheduler
  import sfx_pkg::*;
#(
  parameter int NUM_SFX  = 4,
  parameter int ADDR_W   = 10,
  parameter int TICK_DIV = 6250
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [31:0]               writedata,
  input  logic                      write,
  input  logic                      chipselect,
  input  logic [2:0]                address,
  output logic [NUM_SFX*ADDR_W-1:0] rom_addr,
  input  logic [NUM_SFX*16-1:0]     rom_q,
  input  logic                      left_chan_ready,
  input  logic                      right_chan_ready,
  output logic [15:0]               sample_data_l,
  output logic [15:0]               sample_data_r,
  output logic                      sample_valid_l,
  output logic                      sample_valid_r,
  output logic [NUM_SFX-1:0]        active,
  output logic                      underrun
);

  localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  sfx_state_t       state, state_n;
  logic [CNT_W-1:0] tick_cnt;
  logic             tick;
  logic             reg_wr, wr_trigger, wr_stop;
  logic [2:0]       trig_id;
  logic [NUM_SFX-1:0] v_start, v_stop;
  logic [15:0]      next_sample;
  logic [15:0]      sample_q;
  logic             out_done;
  logic             unused_wd;

  assign tick = (tick_cnt == CNT_W'(TICK_DIV - 1));

  always_ff @(posedge clk) begin
    if (reset || tick) tick_cnt <= '0;
    else               tick_cnt <= tick_cnt + 1'b1;
  end

  assign reg_wr     = write & chipselect;
  assign wr_trigger = reg_wr && (address == REG_TRIGGER);
  assign wr_stop    = reg_wr && (address == REG_STOP);
  assign trig_id    = writedata[2:0];
  assign unused_wd  = ^writedata[30:NUM_SFX];

  genvar v;
  generate
    for (v = 0; v < NUM_SFX; v++) begin : g_voice
      assign v_start[v] = wr_trigger && (trig_id == 3'(v + 1));
      assign v_stop[v]  = (wr_trigger && (trig_id == 3'd0)) || (wr_stop && writedata[v]);

      sfx_voice #(
        .ADDR_W (ADDR_W),
        .LEN    (SFX_LEN[v])
      ) u_voice (
        .clk     (clk),
        .reset   (reset),
        .start   (v_start[v]),
        .stop    (v_stop[v]),
        .advance (state == LATCH),
        .addr    (rom_addr[v*ADDR_W +: ADDR_W]),
        .active  (active[v])
      );
    end
  endgenerate

`ifdef SFX_MIX_EN
  localparam int SUM_W = 16 + $clog2(NUM_SFX);
  logic signed [SUM_W-1:0] mix_sum;

  always_comb begin
    mix_sum = '0;
    for (int i = 0; i < NUM_SFX; i++) begin
      if (active[i]) mix_sum = mix_sum + SUM_W'($signed(rom_q[i*16 +: 16]));
    end
    next_sample = sat16(int'(mix_sum));
  end
`else
  // Walk from the top so the lowest-index active voice is the last to assign
  always_comb begin
    next_sample = '0;
    for (int i = NUM_SFX - 1; i >= 0; i--) begin
      if (active[i]) next_sample = rom_q[i*16 +: 16];
    end
  end
`endif

  assign out_done = (!sample_valid_l || left_chan_ready) && (!sample_valid_r || right_chan_ready);

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (tick) state_n = LATCH;
      LATCH:   state_n = OUT;
      OUT:     if (out_done) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sample_q       <= '0;
      sample_valid_l <= 1'b0;
      sample_valid_r <= 1'b0;
      underrun       <= 1'b0;
    end else begin
      if (state == LATCH) begin
        sample_q       <= next_sample;
        sample_valid_l <= 1'b1;
        sample_valid_r <= 1'b1;
      end else begin
        if (sample_valid_l && left_chan_ready)  sample_valid_l <= 1'b0;
        if (sample_valid_r && right_chan_ready) sample_valid_r <= 1'b0;
      end
      if (tick && (state != IDLE))          underrun <= 1'b1;
      else if (wr_stop && writedata[31])    underrun <= 1'b0;
    end
  end

  assign sample_data_l = sample_q;
  assign sample_data_r = sample_q;

endmodule
